add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 125 ++++++++++++
 tb/tb_add_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle adder: grants one requester,
// holds its operands on the adder and captures the result ADD_LATENCY edges later.
module add_arbiter #(
  parameter int ADD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [4:0] add_c,
  output logic       done0,
  output logic       done1,
  output logic [4:0] sum,
  output logic       busy
);
  // state | meaning
  // IDLE  | sampling requests, adder free
  // WAIT  | winner's operands on the adder, counting down to result capture
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [2:0] LAT = 3'(ADD_LATENCY);

  state_t     r_state, w_state;
  logic [2:0] r_cnt, w_cnt;
  logic       r_last, w_last;     // requester served most recently; resets to 1 so 0 wins the first tie
  logic       r_owner, w_owner;
  logic [3:0] r_add_a, w_add_a;
  logic [3:0] r_add_b, w_add_b;
  logic [4:0] r_sum, w_sum;
  logic       r_gnt0, w_gnt0;
  logic       r_gnt1, w_gnt1;
  logic       r_done0, w_done0;
  logic       r_done1, w_done1;
  logic       r_busy, w_busy;
  logic       w_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_add_a <= 4'd0;
      r_add_b <= 4'd0;
      r_sum   <= 5'd0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      r_owner <= w_owner;
      r_add_a <= w_add_a;
      r_add_b <= w_add_b;
      r_sum   <= w_sum;
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_done0 <= w_done0;
      r_done1 <= w_done1;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_last  = r_last;
    w_owner = r_owner;
    w_add_a = r_add_a;
    w_add_b = r_add_b;
    w_sum   = r_sum;
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    w_win   = (req0 && req1) ? ~r_last : req1;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_state = WAIT;
          w_owner = w_win;
          w_last  = w_win;
          w_add_a = w_win ? a1 : a0;
          w_add_b = w_win ? b1 : b0;
          w_gnt0  = ~w_win;
          w_gnt1  = w_win;
          w_cnt   = LAT;
        end
      end
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state = IDLE;
          w_sum   = add_c;
          w_done0 = ~r_owner;
          w_done1 = r_owner;
        end else begin
          w_cnt = r_cnt - 3'd1;
        end
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state == WAIT);
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign add_a = r_add_a;
  assign add_b = r_add_b;
  assign sum   = r_sum;
  assign busy  = r_busy;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: two instances (latency 1 and 3), each with a delayed adder
// and a cycle-count reference model of grant/done timing and results.
module tb_add_arbiter;
  logic       clk;
  logic       rst_n;
  logic       req0_i [2];
  logic       req1_i [2];
  logic [3:0] a0_i [2];
  logic [3:0] b0_i [2];
  logic [3:0] a1_i [2];
  logic [3:0] b1_i [2];
  // {gnt0, gnt1, done0, done1, busy, sum[4:0]}
  logic [9:0] got_v [2];
  logic [9:0] exp_v [2];
  logic [7:0] got_ab [2];
  logic [7:0] exp_ab [2];
  int         hold [2];
  int         rate [2];
  int         n_checks;
  int         n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic       w_gnt0, w_gnt1, w_done0, w_done1, w_busy;
    logic [3:0] w_add_a, w_add_b;
    logic [4:0] w_add_c, w_sum;
    logic [4:0] pipe [4];

    add_arbiter #(.ADD_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0_i[g]), .a0(a0_i[g]), .b0(b0_i[g]),
      .req1(req1_i[g]), .a1(a1_i[g]), .b1(b1_i[g]),
      .gnt0(w_gnt0), .gnt1(w_gnt1),
      .add_a(w_add_a), .add_b(w_add_b), .add_c(w_add_c),
      .done0(w_done0), .done1(w_done1), .sum(w_sum), .busy(w_busy)
    );

    // shared adder: result appears LAT edges after the operands change
    always @(posedge clk) begin
      pipe[0] <= 5'(w_add_a) + 5'(w_add_b);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign w_add_c = pipe[LAT-1];

    assign got_v[g]  = {w_gnt0, w_gnt1, w_done0, w_done1, w_busy, w_sum};
    assign got_ab[g] = {w_add_a, w_add_b};

    // reference: count edges since reset; a grant at edge E busies the adder until E+LAT+1
    int         m_cyc, m_free, m_done_at, m_last, m_pid, m_win;
    logic [4:0] m_psum, m_sum;
    logic [7:0] m_ab;
    logic [9:0] m_exp;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_cyc = 0; m_free = 0; m_done_at = -1; m_last = 1; m_pid = 0;
        m_sum = 5'd0; m_psum = 5'd0; m_ab = 8'd0; m_exp = 10'd0;
      end else begin
        m_cyc = m_cyc + 1;
        m_exp = 10'd0;
        if (m_cyc == m_done_at) begin
          m_sum = m_psum;
          if (m_pid == 1) m_exp[6] = 1'b1; else m_exp[7] = 1'b1;
        end
        if (m_cyc >= m_free && (req0_i[g] || req1_i[g])) begin
          if (req0_i[g] && req1_i[g]) m_win = 1 - m_last;
          else m_win = req1_i[g] ? 1 : 0;
          m_last = m_win;
          m_pid  = m_win;
          if (m_win == 1) begin
            m_exp[8] = 1'b1;
            m_ab     = {a1_i[g], b1_i[g]};
            m_psum   = 5'(a1_i[g]) + 5'(b1_i[g]);
          end else begin
            m_exp[9] = 1'b1;
            m_ab     = {a0_i[g], b0_i[g]};
            m_psum   = 5'(a0_i[g]) + 5'(b0_i[g]);
          end
          m_done_at = m_cyc + LAT + 1;
          m_free    = m_cyc + LAT + 2;
        end
        m_exp[5]   = (m_cyc <= m_free - 2);
        m_exp[4:0] = m_sum;
      end
    end
    assign exp_v[g]  = m_exp;
    assign exp_ab[g] = m_ab;
  end

  // one clock; requesters react to grants at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      if (req0_i[g] && got_v[g][9]) begin
        if (hold[g] != 0) begin a0_i[g] = 4'($urandom); b0_i[g] = 4'($urandom); end
        else req0_i[g] = 1'b0;
      end
      if (req1_i[g] && got_v[g][8]) begin
        if (hold[g] != 0) begin a1_i[g] = 4'($urandom); b1_i[g] = 4'($urandom); end
        else req1_i[g] = 1'b0;
      end
      if (!req0_i[g] && int'($urandom_range(99)) < rate[g]) begin
        req0_i[g] = 1'b1; a0_i[g] = 4'($urandom); b0_i[g] = 4'($urandom);
      end
      if (!req1_i[g] && int'($urandom_range(99)) < rate[g]) begin
        req1_i[g] = 1'b1; a1_i[g] = 4'($urandom); b1_i[g] = 4'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin req0_i[g] = 1'b0; req1_i[g] = 1'b0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (got_v[g] !== 10'd0) begin
        n_err++; $display("FAIL reset_outputs inst%0d got=%b exp=%b", g, got_v[g], 10'd0);
      end
      n_checks++;
      if (got_ab[g] !== 8'd0) begin
        n_err++; $display("FAIL reset_operands inst%0d got=%h exp=00", g, got_ab[g]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [9:0] tab [4];
    tab = '{10'b1000_1_00000, 10'b0000_1_00000, 10'b0010_0_00011, 10'b0000_0_00011};
    do_reset();
    req0_i[0] = 1'b1; a0_i[0] = 4'd1; b0_i[0] = 4'd2;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (got_v[0] !== tab[c]) begin
        n_err++; $display("FAIL single c%0d got=%b exp=%b", c + 1, got_v[0], tab[c]);
      end
      if (c == 0) begin
        n_checks++;
        if (got_ab[0] !== 8'h12) begin
          n_err++; $display("FAIL single_operands got=%h exp=12", got_ab[0]);
        end
      end
    end
  endtask

  task automatic test_tie();
    logic [9:0] tab [7];
    tab = '{10'b1000_1_00000, 10'b0000_1_00000, 10'b0010_0_01000, 10'b0100_1_01000,
            10'b0000_1_01000, 10'b0001_0_11110, 10'b0000_0_11110};
    do_reset();
    req0_i[0] = 1'b1; a0_i[0] = 4'd3;  b0_i[0] = 4'd5;
    req1_i[0] = 1'b1; a1_i[0] = 4'd15; b1_i[0] = 4'd15;
    for (int c = 0; c < 7; c++) begin
      step();
      n_checks++;
      if (got_v[0] !== tab[c]) begin
        n_err++; $display("FAIL tie c%0d got=%b exp=%b", c + 1, got_v[0], tab[c]);
      end
    end
  endtask

  task automatic test_alternate();
    int prev, pend, ngr, owner;
    prev = 1; pend = -1; ngr = 0;
    hold[0] = 1;
    req0_i[0] = 1'b1; a0_i[0] = 4'($urandom); b0_i[0] = 4'($urandom);
    req1_i[0] = 1'b1; a1_i[0] = 4'($urandom); b1_i[0] = 4'($urandom);
    for (int c = 0; c < 30; c++) begin
      step();
      n_checks++;
      if (got_v[0] !== exp_v[0]) begin
        n_err++; $display("FAIL alt_model t=%0t got=%b exp=%b", $time, got_v[0], exp_v[0]);
      end
      if (got_v[0][9] || got_v[0][8]) begin
        owner = got_v[0][8] ? 1 : 0;
        n_checks++;
        if (owner == prev) begin
          n_err++; $display("FAIL alt_order t=%0t got=%0d exp=%0d", $time, owner, 1 - prev);
        end
        prev = owner; pend = owner; ngr++;
      end
      if (got_v[0][7] || got_v[0][6]) begin
        n_checks++;
        if ((got_v[0][6] ? 1 : 0) != pend) begin
          n_err++; $display("FAIL alt_done_owner t=%0t got=%0d exp=%0d", $time, got_v[0][6], pend);
        end
      end
    end
    n_checks++;
    if (ngr < 9) begin
      n_err++; $display("FAIL alt_grant_count got=%0d exp>=9", ngr);
    end
    hold[0] = 0; req0_i[0] = 1'b0; req1_i[0] = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_busy();
    logic [9:0] tab [4];
    tab = '{10'b0100_1_00000, 10'b0000_1_00000, 10'b0001_0_10000, 10'b0000_0_10000};
    req0_i[0] = 1'b1; a0_i[0] = 4'd9; b0_i[0] = 4'd4;
    step();
    n_checks++;
    if (got_v[0][5] !== 1'b1) begin
      n_err++; $display("FAIL rstbusy_pre busy got=%b exp=1", got_v[0][5]);
    end
    #2 rst_n = 1'b0;
    req0_i[0] = 1'b0;
    #1;
    n_checks++;
    if (got_v[0] !== 10'd0 || got_ab[0] !== 8'd0) begin
      n_err++; $display("FAIL rstbusy_immediate got=%b/%h exp=0/00", got_v[0], got_ab[0]);
    end
    #7 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (got_v[0][7:6] !== 2'b00 || got_v[0] !== exp_v[0]) begin
        n_err++; $display("FAIL rstbusy_no_done c%0d got=%b exp=%b", c, got_v[0], exp_v[0]);
      end
    end
    req1_i[0] = 1'b1; a1_i[0] = 4'd7; b1_i[0] = 4'd9;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (got_v[0] !== tab[c]) begin
        n_err++; $display("FAIL rstbusy_after c%0d got=%b exp=%b", c + 1, got_v[0], tab[c]);
      end
    end
  endtask

  task automatic test_latency3();
    logic [9:0] tab [6];
    tab = '{10'b0100_1_00000, 10'b0000_1_00000, 10'b0000_1_00000, 10'b0000_1_00000,
            10'b0001_0_10000, 10'b0100_1_10000};
    do_reset();
    hold[1] = 1;
    req1_i[1] = 1'b1; a1_i[1] = 4'd15; b1_i[1] = 4'd1;
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++;
      if (got_v[1] !== tab[c]) begin
        n_err++; $display("FAIL lat3 c%0d got=%b exp=%b", c + 1, got_v[1], tab[c]);
      end
      if (c < 4) begin
        n_checks++;
        if (got_ab[1] !== 8'hF1) begin
          n_err++; $display("FAIL lat3_operands c%0d got=%h exp=f1", c + 1, got_ab[1]);
        end
      end
    end
    hold[1] = 0; req1_i[1] = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_random();
    rate[0] = 35; rate[1] = 35;
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 0) begin hold[0] = int'($urandom_range(1)); hold[1] = int'($urandom_range(1)); end
      step();
      for (int g = 0; g < 2; g++) begin
        n_checks++;
        if (got_v[g] !== exp_v[g]) begin
          n_err++; $display("FAIL random inst%0d t=%0t got=%b exp=%b", g, $time, got_v[g], exp_v[g]);
        end
        if (exp_v[g][5]) begin
          n_checks++;
          if (got_ab[g] !== exp_ab[g]) begin
            n_err++; $display("FAIL random_operands inst%0d t=%0t got=%h exp=%h", g, $time, got_ab[g], exp_ab[g]);
          end
        end
      end
    end
    rate[0] = 0; rate[1] = 0; hold[0] = 0; hold[1] = 0;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req0_i[g] = 1'b0; req1_i[g] = 1'b0;
      a0_i[g] = 4'd0; b0_i[g] = 4'd0; a1_i[g] = 4'd0; b1_i[g] = 4'd0;
      hold[g] = 0; rate[g] = 0;
    end
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_reset_busy();
    test_latency3();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
